sub_word_mem: RTL and testbench
===============================

# sub_word_mem

Multi-cycle load/store alignment unit between the MIPS32 core's memory stage and a 32-bit word-addressed data memory. It converts lb/lbu/lh/lhu/lw requests into word reads and lane-extracts the result with sign or zero extension. It converts sb/sh/sw requests into word writes, using read-modify-write for sub-word stores so the narrow data is merged into the existing word. It is the store-side and memory-side counterpart of the immediate extender.

## Interface
- ADDR_W, 32, width of CPU and memory address buses
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  1  request; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 word, 01 half, 10 byte, 11 reserved
- uns  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- addr  in  ADDR_W  byte address
- wdata  in  32  store data; byte uses [7:0], half uses [15:0]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  pulses with done on a misaligned access or reserved size
- rdata  out  32  extended load result; holds its value until the next successful load
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word address, {addr[ADDR_W-1:2], 2'b00}
- mem_wdata  out  32  write word
- mem_ack  in  1  memory completion; a transfer occurs on an edge with mem_req && mem_ack
- mem_rdata  in  32  read word, valid when mem_ack is high

## Operation
- Byte order is little-endian. Byte lane k = [8k+7:8k] with k = addr[1:0]. Half lane h = [16h+15:16h] with h = addr[1].
- FSM states: IDLE, RD, WR, DONE. All outputs are registered or decoded from the state only (Moore).
- IDLE: on req=1, latch we, size, uns, addr and wdata. Next state:
  - DONE with err=1 if size=11, or half with addr[0]=1, or word with addr[1:0]≠0. No memory access is made.
  - RD for any load.
  - WR for a word store.
  - RD for a byte or half store.
- RD: mem_req=1, mem_we=0. Stay until mem_ack=1, then capture mem_rdata.
  - Load: rdata ← extracted lane. Byte is extended from bit 7, half from bit 15; uns selects zero fill instead. Go to DONE.
  - Sub-word store: mem_wdata ← captured word with the addressed lane replaced by wdata[7:0] or wdata[15:0]. Go to WR.
- WR: mem_req=1, mem_we=1. For a word store, mem_wdata = wdata. Stay until mem_ack=1, then go to DONE.
- DONE: done=1, and err as latched. Go to IDLE next cycle.
- req is ignored outside IDLE, and no request is queued.
- rdata is unchanged by stores and by errored accesses.
- mem_addr, mem_we and mem_wdata are stable for as long as mem_req is high.

## Timing
- Reset values: busy 0, done 0, err 0, rdata 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, state IDLE.
- Asserting rst_n mid-transaction drops mem_req immediately (asynchronous reset). The transaction is abandoned: no done pulse and no write.
- Latencies below are counted in cycles from the accept edge E0, which is the edge where IDLE sees req=1. W is the number of wait cycles before mem_ack.
  - Load: RD covers cycles 1..1+W. done is high in cycle 2+W. The earliest next accept is at edge E3+W.
  - Word store: same timing as a load, with WR in place of RD.
  - Sub-word store: RD then WR. With zero waits, done is high in cycle 3.
  - Error: done=err=1 in cycle 1. mem_req stays 0 throughout.
- A mem_ack that arrives while mem_req=0 is ignored.

## Test plan
- Sign/zero byte load:
  - Memory[0x100]=0x12F45678. lb at 0x102 → one read at 0x100, rdata=0xFFFFFFF4.
  - lbu at 0x102 → rdata=0x000000F4.
- Half load:
  - Memory[0x100]=0x80017FFF. lh at 0x102 → rdata=0xFFFF8001.
  - lh at 0x100 → rdata=0x00007FFF.
  - lhu at 0x102 → rdata=0x00008001.
- Byte store RMW:
  - Memory[0x200]=0x11223344. sb at 0x201 with wdata=0xAAAAAA99 → read at 0x200, then write 0x11229944 to 0x200.
  - One done pulse; rdata unchanged.
- Word store: sw at 0x300 with wdata=0xDEADBEEF → no read, a single write of 0xDEADBEEF to 0x300, done in cycle 2 with zero waits.
- Errors: lh at 0x103, lw at 0x102, and any access with size=11 → done=err=1 in cycle 1, mem_req never asserted, rdata unchanged.
- Wait states and reset:
  - mem_ack delayed 3 cycles with req held high while busy → exactly one transfer, done in cycle 5.
  - Assert rst_n during RD of an sb → mem_req falls immediately, memory is unchanged, and the next lw completes normally.

Source files
------------

// File: rtl/sub_word_mem_if.sv
// Bundle of the CPU-side request/response signals and the word-memory port of
// the load/store alignment unit.
//   CPU side : req, we, size, uns, addr, wdata -> unit; busy, done, err, rdata <- unit
//   Mem side : mem_req, mem_we, mem_addr, mem_wdata <- unit; mem_ack, mem_rdata -> unit
// Modports:
//   slave  - the alignment unit itself
//   master - the environment (requesting core plus memory responder)
interface sub_word_mem_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req, we, size, uns, addr, wdata, mem_ack, mem_rdata,
        output busy, done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, size, uns, addr, wdata, mem_ack, mem_rdata,
        input  busy, done, err, rdata, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sub_word_mem.sv
// Load/store alignment unit between the core's memory stage and a 32-bit
// word-addressed data memory. Loads become one word read with lane extraction
// and sign/zero extension; word stores become one write; byte/half stores are
// read-modify-write. Misaligned accesses and the reserved size finish at once
// with err and no memory traffic.
// Ports:
//   clk, rst_n - clock (rising edge) and asynchronous active-low reset
//   bus        - sub_word_mem_if.slave: CPU request/response and memory port
module sub_word_mem #(
    parameter int unsigned ADDR_W = 32
) (
    input logic           clk,
    input logic           rst_n,
    sub_word_mem_if.slave bus
);
    localparam int unsigned DATA_W  = 32;
    localparam logic [1:0]  SZ_WORD = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t state, state_next;

    // Request fields captured at accept time
    logic        lat_we,    lat_we_next;
    logic [1:0]  lat_size,  lat_size_next;
    logic        lat_uns,   lat_uns_next;
    logic [1:0]  lat_off,   lat_off_next;
    logic [15:0] lat_wdata, lat_wdata_next;

    logic              busy_q, done_q, err_q, mem_req_q, mem_we_q;
    logic              err_next;
    logic [DATA_W-1:0] rdata_q, rdata_next;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_next;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_next;
    logic              bad_c;

    // Pick the addressed lane and extend it to a full word
    function automatic logic [DATA_W-1:0] lane_extract(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        sz,
        input logic              zext,
        input logic [1:0]        off
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (sz)
            SZ_BYTE: r = {{24{b[7] & ~zext}}, b};
            SZ_HALF: r = {{16{h[15] & ~zext}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overwrite the addressed lane of the word read back from memory
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        sz,
        input logic [1:0]        off,
        input logic [15:0]       data
    );
        logic [DATA_W-1:0] r;
        r = word;
        if (sz == SZ_BYTE) begin
            r[{off, 3'b000} +: 8] = data[7:0];
        end else begin
            r[{off[1], 4'b0000} +: 16] = data;
        end
        return r;
    endfunction

    // Reserved size or address not a multiple of the access size
    always_comb begin
        case (bus.size)
            SZ_WORD: bad_c = (bus.addr[1:0] != 2'b00);
            SZ_HALF: bad_c = bus.addr[0];
            SZ_BYTE: bad_c = 1'b0;
            default: bad_c = 1'b1;
        endcase
    end

    // Next-state and next-register values
    always_comb begin
        state_next     = state;
        lat_we_next    = lat_we;
        lat_size_next  = lat_size;
        lat_uns_next   = lat_uns;
        lat_off_next   = lat_off;
        lat_wdata_next = lat_wdata;
        rdata_next     = rdata_q;
        mem_addr_next  = mem_addr_q;
        mem_wdata_next = mem_wdata_q;
        err_next       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req) begin
                    lat_we_next    = bus.we;
                    lat_size_next  = bus.size;
                    lat_uns_next   = bus.uns;
                    lat_off_next   = bus.addr[1:0];
                    lat_wdata_next = bus.wdata[15:0];
                    if (bad_c) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        mem_addr_next = {bus.addr[ADDR_W-1:2], 2'b00};
                        if (bus.we && (bus.size == SZ_WORD)) begin
                            mem_wdata_next = bus.wdata;
                            state_next     = WR;
                        end else begin
                            state_next = RD;
                        end
                    end
                end
            end
            RD: begin
                if (bus.mem_ack) begin
                    if (lat_we) begin
                        mem_wdata_next = lane_merge(bus.mem_rdata, lat_size, lat_off, lat_wdata);
                        state_next     = WR;
                    end else begin
                        rdata_next = lane_extract(bus.mem_rdata, lat_size, lat_uns, lat_off);
                        state_next = DONE;
                    end
                end
            end
            WR: begin
                if (bus.mem_ack) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs; status flags track the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lat_we      <= 1'b0;
            lat_size    <= 2'b00;
            lat_uns     <= 1'b0;
            lat_off     <= 2'b00;
            lat_wdata   <= 16'h0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state       <= state_next;
            lat_we      <= lat_we_next;
            lat_size    <= lat_size_next;
            lat_uns     <= lat_uns_next;
            lat_off     <= lat_off_next;
            lat_wdata   <= lat_wdata_next;
            busy_q      <= (state_next != IDLE);
            done_q      <= (state_next == DONE);
            err_q       <= err_next;
            mem_req_q   <= (state_next == RD) || (state_next == WR);
            mem_we_q    <= (state_next == WR);
            rdata_q     <= rdata_next;
            mem_addr_q  <= mem_addr_next;
            mem_wdata_q <= mem_wdata_next;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_sub_word_mem.sv
// Scoreboard bench for sub_word_mem: a byte-level reference model predicts
// each access, a memory responder with random wait states serves the unit,
// and a monitor checks every done pulse against the queued prediction.
module tb_sub_word_mem;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned NWORDS = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sub_word_mem_if #(.ADDR_W(ADDR_W)) bus ();
    sub_word_mem #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          kind;      // 0 error, 1 single transfer, 2 read-modify-write
        int          nrd;
        int          nwr;
        logic [31:0] waddr;
        logic [9:0]  widx;
        logic [31:0] memword;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          mon_lat;
    logic [31:0] dmem [NWORDS];
    logic [31:0] rmem [NWORDS];
    logic [31:0] model_rdata;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          n_rd = 0;
    int          n_wr = 0;
    int          tx_waits = 0;
    int          force_wait = -1;
    int          wait_left = -1;
    bit          saw_req = 1'b0;
    bit          prev_req = 1'b0;
    bit          xfer_seen = 1'b0;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] snap_addr = 32'h0;
    logic [31:0] snap_wdata = 32'h0;
    logic        snap_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    function automatic int unsigned nbytes_of(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4;
            2'b01:   return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        return (a % nbytes_of(sz)) != 0;
    endfunction

    // Little-endian load of n bytes starting at byte offset a%4
    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic u, input logic [31:0] a);
        longint unsigned v, mask;
        int unsigned n, sh;
        n    = nbytes_of(sz);
        sh   = (a % 4) * 8;
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = ({32'd0, word} >> sh) & mask;
        if (!u && (n < 4) && v[8 * n - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        int unsigned base;
        r    = word;
        base = a % 4;
        for (int i = 0; i < int'(nbytes_of(sz)); i++) r[8 * (base + i) +: 8] = d[8 * i +: 8];
        return r;
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        dmem[a[11:2]] = v;
        rmem[a[11:2]] = v;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record memory transfers and apply writes on the transfer edge
    always @(posedge clk) begin
        if (rst_n && bus.mem_req && bus.mem_ack) begin
            if (bus.mem_we) begin
                dmem[bus.mem_addr[11:2]] = bus.mem_wdata;
                n_wr++;
            end else begin
                n_rd++;
            end
            last_addr = bus.mem_addr;
            xfer_seen = 1'b1;
        end
    end

    // Memory responder with random wait states and stray acks while idle
    always @(negedge clk) begin
        if (rst_n && bus.mem_req && prev_req && !xfer_seen) begin
            check("mem_stable_addr", bus.mem_addr, snap_addr);
            check("mem_stable_we", 32'(bus.mem_we), 32'(snap_we));
            check("mem_stable_wdata", bus.mem_wdata, snap_wdata);
        end
        snap_addr  = bus.mem_addr;
        snap_we    = bus.mem_we;
        snap_wdata = bus.mem_wdata;
        prev_req   = rst_n && bus.mem_req;
        xfer_seen  = 1'b0;

        bus.mem_ack = 1'b0;
        if (!rst_n) begin
            wait_left = -1;
        end else if (bus.mem_req) begin
            saw_req = 1'b1;
            if (wait_left < 0) begin
                if (force_wait >= 0) wait_left = force_wait;
                else wait_left = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            if (wait_left == 0) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = dmem[bus.mem_addr[11:2]];
                wait_left     = -1;
            end else begin
                wait_left--;
                tx_waits++;
                bus.mem_rdata = $urandom;
            end
        end else begin
            wait_left     = -1;
            bus.mem_ack   = ($urandom_range(0, 7) == 0);
            bus.mem_rdata = $urandom;
        end
    end

    // Completion monitor: pop the prediction and compare
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sbq.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                mon_e = sbq.pop_front();
                check("err", 32'(bus.err), 32'(mon_e.err));
                check("rdata", bus.rdata, mon_e.rdata);
                mon_lat = (mon_e.kind == 0) ? 1 : (mon_e.kind == 1) ? 2 + tx_waits : 3 + tx_waits;
                check("latency", 32'(cyc - acc_cyc), 32'(mon_lat));
                check("n_reads", 32'(n_rd), 32'(mon_e.nrd));
                check("n_writes", 32'(n_wr), 32'(mon_e.nwr));
                check("mem_req_seen", 32'(saw_req), 32'(!mon_e.err));
                if (!mon_e.err) check("mem_addr", last_addr, mon_e.waddr);
                check("mem_word", dmem[mon_e.widx], mon_e.memword);
            end
        end else if (rst_n && bus.err) begin
            fail_now("err_without_done");
        end
    end

    task automatic wait_idle();
        int guard;
        guard = 0;
        @(negedge clk);
        while (bus.busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) fail_now("idle_timeout");
    endtask

    // Predict, issue one request and wait for its completion to be checked
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, input int fw, input bit hold);
        exp_t e;
        int   guard;
        wait_idle();
        e.widx  = a[11:2];
        e.waddr = {a[31:2], 2'b00};
        e.err   = ref_err(sz, a);
        if (e.err) begin
            e.kind = 0; e.nrd = 0; e.nwr = 0;
        end else if (!w) begin
            model_rdata = ref_load(rmem[e.widx], sz, u, a);
            e.kind = 1; e.nrd = 1; e.nwr = 0;
        end else if (sz == 2'b00) begin
            rmem[e.widx] = d;
            e.kind = 1; e.nrd = 0; e.nwr = 1;
        end else begin
            rmem[e.widx] = ref_store(rmem[e.widx], sz, a, d);
            e.kind = 2; e.nrd = 1; e.nwr = 1;
        end
        e.rdata   = model_rdata;
        e.memword = rmem[e.widx];
        sbq.push_back(e);

        bus.req = 1'b1; bus.we = w; bus.size = sz; bus.uns = u; bus.addr = a; bus.wdata = d;
        force_wait = fw;
        acc_cyc = cyc; n_rd = 0; n_wr = 0; tx_waits = 0; saw_req = 1'b0;
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.req = 1'b0;
            bus.we = 1'($urandom); bus.size = 2'($urandom); bus.uns = 1'($urandom);
            bus.addr = $urandom; bus.wdata = $urandom;
        end
        guard = 0;
        while (sbq.size() != 0 && guard < 60) begin
            @(negedge clk);
            if (bus.done) bus.req = 1'b0;
            guard++;
        end
        bus.req = 1'b0;
        if (guard >= 60) begin
            fail_now("done_timeout");
            sbq.delete();
        end
        force_wait = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.uns = 1'b0;
        bus.addr = 32'h0; bus.wdata = 32'h0; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        for (int i = 0; i < int'(NWORDS); i++) begin
            dmem[i] = $urandom;
            rmem[i] = dmem[i];
        end
        model_rdata = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        rst_n = 1'b1;

        // Byte loads, sign and zero extended
        set_word(32'h100, 32'h12F45678);
        issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, 1'b0);
        check("lb_value", bus.rdata, 32'hFFFFFFF4);
        issue(1'b0, 2'b10, 1'b1, 32'h102, 32'h0, 0, 1'b0);
        check("lbu_value", bus.rdata, 32'h000000F4);

        // Half loads
        set_word(32'h100, 32'h80017FFF);
        issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 1'b0);
        check("lh_hi_value", bus.rdata, 32'hFFFF8001);
        issue(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 0, 1'b0);
        check("lh_lo_value", bus.rdata, 32'h00007FFF);
        issue(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 0, 1'b0);
        check("lhu_value", bus.rdata, 32'h00008001);

        // Byte store read-modify-write; rdata must keep the last load
        set_word(32'h200, 32'h11223344);
        issue(1'b1, 2'b10, 1'b0, 32'h201, 32'hAAAAAA99, 0, 1'b0);
        check("sb_mem", dmem[32'h200 >> 2], 32'h11229944);
        check("sb_rdata_kept", bus.rdata, 32'h00008001);

        // Word store: single write, done in cycle 2
        issue(1'b1, 2'b00, 1'b0, 32'h300, 32'hDEADBEEF, 0, 1'b0);
        check("sw_mem", dmem[32'h300 >> 2], 32'hDEADBEEF);

        // Misaligned and reserved-size accesses
        issue(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 0, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 0, 1'b0);
        issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 0, 1'b0);
        issue(1'b1, 2'b11, 1'b0, 32'h204, 32'h12345678, 0, 1'b1);
        check("err_rdata_kept", bus.rdata, 32'h00008001);

        // Three wait states with req held high throughout: one transfer, done in cycle 5
        issue(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 3, 1'b1);
        check("wait_lw_value", bus.rdata, 32'h80017FFF);

        // Reset in the read phase of a byte store abandons it
        set_word(32'h240, 32'hCAFEF00D);
        wait_idle();
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.uns = 1'b0;
        bus.addr = 32'h242; bus.wdata = 32'h00000055;
        force_wait = 6;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_req_before", 32'(bus.mem_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        model_rdata = 32'h0;
        check("rst_mid_req_after", 32'(bus.mem_req), 32'h0);
        check("rst_mid_busy", 32'(bus.busy), 32'h0);
        check("rst_mid_done", 32'(bus.done), 32'h0);
        check("rst_mid_rdata", bus.rdata, model_rdata);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        force_wait = -1;
        check("rst_mid_mem_unchanged", dmem[32'h240 >> 2], 32'hCAFEF00D);
        issue(1'b0, 2'b00, 1'b0, 32'h240, 32'h0, -1, 1'b0);
        check("rst_next_lw", bus.rdata, 32'hCAFEF00D);

        // Randomized mix against the reference model
        for (int t = 0; t < 300; t++) begin
            logic        w;
            logic [1:0]  sz;
            logic [31:0] a;
            w  = 1'($urandom);
            sz = 2'($urandom);
            if (sz == 2'b11 && $urandom_range(0, 3) != 0) sz = 2'b10;
            a = {($urandom_range(0, 3) == 0) ? 20'($urandom) : 20'd0, 12'($urandom_range(0, 255))};
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'b00) a[1:0] = 2'b00;
                else if (sz == 2'b01) a[0] = 1'b0;
            end
            issue(w, sz, 1'($urandom), a, $urandom, -1, ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        if (sbq.size() != 0) fail_now("scoreboard_leftover");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
